// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Latency: none, wires only; imem_rdata is sampled on the edge where imem_ack=1.
// Backpressure: imem_req stays high with a stable imem_addr until acked.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, issues one imem request at a time, registers word + PC.
// Latency: word is visible on o_instr the cycle after its imem ack; one dead cycle after reset.
// Backpressure: i_stall holds a valid word (HOLD, no request); redirects flush regardless of stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 i_redirect,
    input  logic [31:0]          i_redirect_pc,
    input  logic                 i_stall,
    output logic [31:0]          o_instr,
    output logic [31:0]          o_instr_pc,
    output logic                 o_instr_valid,
    output logic [6:0]           o_opcode,
    output logic [2:0]           o_funct3,
    output logic                 o_misalign_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_SQUASH} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_misalign, w_misalign_nxt;

    logic        w_req;
    logic        w_ack;
    logic        w_slot_free;
    logic [31:0] w_redir_tgt;

    // A request is outstanding in FETCH and SQUASH; ack without request is ignored.
    assign w_req       = (r_state == S_FETCH) || (r_state == S_SQUASH);
    assign w_ack       = w_req && imem.imem_ack;
    assign w_slot_free = !r_valid || !i_stall;
    assign w_redir_tgt = {i_redirect_pc[31:2], 2'b00};

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign o_instr        = r_instr;
    assign o_instr_pc     = r_instr_pc;
    assign o_instr_valid  = r_valid;
    assign o_opcode       = r_instr[6:0];
    assign o_funct3       = r_instr[14:12];
    assign o_misalign_err = r_misalign;

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_target   <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= 32'h0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_target   <= w_target_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // Next state: consume/capture per state, then redirect overrides everything outside IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_target_nxt   = r_target;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_misalign_nxt = r_misalign;

        // Downstream takes the word this edge; a fresh capture below replaces it.
        if (r_valid && !i_stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!w_slot_free) begin
                    // Output slot occupied: leave the ack unsampled, refetch same PC later.
                    w_state_nxt = S_HOLD;
                end else if (w_ack) begin
                    w_instr_nxt    = imem.imem_rdata;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = r_pc + 32'd4;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_SQUASH: begin
                // Wrong-path word is drained and dropped before fetching the target.
                if (w_ack) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (i_redirect && (r_state != S_IDLE)) begin
            w_valid_nxt    = 1'b0;
            w_instr_nxt    = NOP_INSTR;
            w_instr_pc_nxt = r_instr_pc;
            if (i_redirect_pc[1:0] != 2'b00) begin
                w_misalign_nxt = 1'b1;
            end
            if (w_req && !w_ack) begin
                w_pc_nxt     = r_pc;
                w_target_nxt = w_redir_tgt;
                w_state_nxt  = S_SQUASH;
            end else begin
                w_pc_nxt    = w_redir_tgt;
                w_state_nxt = S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized stall/redirect/latency traffic.
// Latency: checks sampled on the falling edge; the memory model acks after a per-request wait.
// Backpressure: stall is driven randomly; the scoreboard expects an in-order, gap-free PC stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic [31:0] o_instr, o_instr_pc;
    logic        o_instr_valid;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic        o_misalign_err;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_stall        (i_stall),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .o_instr_valid  (o_instr_valid),
        .o_opcode       (o_opcode),
        .o_funct3       (o_funct3),
        .o_misalign_err (o_misalign_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: next PC the program stream must deliver, sticky error, memory wait.
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        flush_chk;
    logic        prev_pend;
    logic [31:0] prev_addr;
    int          wait_cnt;
    int          mem_lat;
    bit          lat_rand;
    int          idle_run;
    int          consumed;

    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [6:0]  s_op;
    logic [2:0]  s_f3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hC3A5_F00C;
    endfunction

    task automatic model_reset();
        exp_pc    = RESET_PC;
        exp_mis   = 1'b0;
        flush_chk = 1'b0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        wait_cnt  = 0;
        idle_run  = 0;
    endtask

    task automatic reset_checks();
        chk("rst_req",   {31'b0, imem.imem_req}, 32'd0);
        chk("rst_addr",  imem.imem_addr, RESET_PC);
        chk("rst_instr", o_instr, NOP);
        chk("rst_ipc",   o_instr_pc, 32'd0);
        chk("rst_valid", {31'b0, o_instr_valid}, 32'd0);
        chk("rst_mis",   {31'b0, o_misalign_err}, 32'd0);
        chk("rst_op",    {25'b0, o_opcode}, 32'h13);
    endtask

    // One clock: sample outputs, check them against the stream model, then drive the next inputs.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
        bit ack;
        logic [31:0] w;
        @(negedge clk);
        s_req = imem.imem_req;  s_addr = imem.imem_addr;
        s_valid = o_instr_valid; s_instr = o_instr; s_pc = o_instr_pc;
        s_op = o_opcode; s_f3 = o_funct3; s_mis = o_misalign_err;

        if (s_req && prev_pend) chk("addr_stable", s_addr, prev_addr);
        if (flush_chk) chk("flush_valid", {31'b0, s_valid}, 32'd0);
        if (!s_valid) begin
            chk("nop_instr", s_instr, NOP);
            chk("nop_opcode", {25'b0, s_op}, 32'h13);
        end
        chk("misalign", {31'b0, s_mis}, {31'b0, exp_mis});
        w = s_addr;
        chk("addr_align", {30'b0, w[1:0]}, 32'd0);

        ack = s_req && (wait_cnt >= mem_lat);
        imem.imem_ack   = ack;
        imem.imem_rdata = ack ? memfn(s_addr) : $urandom();
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;

        if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
            flush_chk = 1'b1;
            idle_run  = 0;
        end else begin
            flush_chk = 1'b0;
            if (s_valid && !stall) begin
                w = memfn(exp_pc);
                chk("stream_pc", s_pc, exp_pc);
                chk("stream_instr", s_instr, w);
                chk("stream_op", {25'b0, s_op}, {25'b0, w[6:0]});
                chk("stream_f3", {29'b0, s_f3}, {29'b0, w[14:12]});
                exp_pc = exp_pc + 32'd4;
                consumed++;
                idle_run = 0;
            end else if (!stall) begin
                idle_run++;
            end
        end

        if (s_req) begin
            if (ack) begin
                wait_cnt = 0;
                if (lat_rand) mem_lat = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
            prev_pend = !ack;
            prev_addr = s_addr;
        end else begin
            wait_cnt  = 0;
            prev_pend = 1'b0;
        end

        if (idle_run > 200) begin
            chk("liveness", idle_run, 32'd0);
            idle_run = 0;
        end
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_stall = 1'b0;
        imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
        mem_lat = 0; lat_rand = 1'b0; consumed = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks();

        // Zero-wait memory, no stall: one dead cycle, then one word per cycle.
        rst_n = 1'b1;
        #1 chk("idle_req", {31'b0, imem.imem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                chk("dead_valid", {31'b0, s_valid}, 32'd0);
                chk("first_req", {31'b0, s_req}, 32'd1);
            end else begin
                chk("tput_valid", {31'b0, s_valid}, 32'd1);
                chk("tput_pc", s_pc, 32'(4 * (i - 1)));
            end
        end

        // Stall for three edges while word 0x10 is presented.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk("hold_pc", s_pc, 32'h10);
            chk("hold_valid", {31'b0, s_valid}, 32'd1);
            if (k > 0) chk("hold_req", {31'b0, s_req}, 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0);
        chk("release_pc", s_pc, 32'h10);
        cycle(1'b0, 1'b0, 32'h0);
        chk("refetch_addr", s_addr, 32'h14);
        cycle(1'b0, 1'b0, 32'h0);
        chk("after_hold_pc", s_pc, 32'h14);

        // Three-cycle memory, redirect one cycle into the wait.
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 32'h0);
        chk("squash_req", {31'b0, s_req}, 32'd1);
        chk("squash_addr", s_addr, 32'h1C);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_valid) begin
                got = 1'b1;
                chk("redir_pc", s_pc, 32'h100);
            end
        end
        if (!got) chk("redir_timeout", 32'd0, 32'd1);

        // Misaligned redirect coincident with a zero-wait ack.
        mem_lat = 0;
        cycle(1'b0, 1'b1, 32'h202);
        cycle(1'b0, 1'b0, 32'h0);
        chk("mis_flush", {31'b0, s_valid}, 32'd0);
        chk("mis_set", {31'b0, s_mis}, 32'd1);
        cycle(1'b0, 1'b0, 32'h0);
        chk("mis_pc", s_pc, 32'h200);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", s_pc, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_pc2", s_pc, 32'h0000_0004);
        chk("mis_sticky", {31'b0, s_mis}, 32'd1);

        // Reset while a request is pending; ack arrives during reset.
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("pre_rst_req", {31'b0, s_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; i_redirect = 1'b0; i_stall = 1'b0;
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        #1 reset_checks();
        repeat (2) @(negedge clk);
        reset_checks();
        imem.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_reset();
        mem_lat = 0;
        cycle(1'b0, 1'b0, 32'h0);
        chk("rst2_dead", {31'b0, s_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("rst2_pc", s_pc, RESET_PC);

        // Random traffic: stalls, redirects (some misaligned), latency 0..3.
        lat_rand = 1'b1;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            bit st, rd;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 6);
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cycle(st, rd, tgt);
        end
        chk("progress", {31'b0, (consumed > 200)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
